// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and slot state type for the stream demux
package stream_demux_pkg;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/stream_demux_slot.sv
// rtl/stream_demux_slot.sv - one-entry holding register for a single demux output channel
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e state;
    slot_state_e state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                data <= data_in;
            end
        end
    end

    // A load while draining keeps the slot full: that is the pass-through case.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (load) state_next = SLOT_FULL;
            SLOT_FULL:  if (ready && !load) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/stream_demux_1ton.sv
// rtl/stream_demux_1ton.sv - 1-to-N valid/ready stream demux with broadcast and drop; STREAM_DEMUX_STATS_EN adds counters
module stream_demux_1ton
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OUT = 4,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic                     drop_pulse
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [NUM_OUT*STAT_W-1:0] stat_cnt,
    output logic [STAT_W-1:0]         drop_cnt
`endif
);

    logic [NUM_OUT-1:0] can_load;
    logic [NUM_OUT-1:0] sel_hit;
    logic [NUM_OUT-1:0] load;
    logic               in_range;
    logic               accept;
    logic               drop;

    assign can_load = ~out_valid | out_ready;
    assign in_range = (int'(in_sel) < NUM_OUT);

    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (in_bcast || (int'(in_sel) == k)) begin
                sel_hit[k] = 1'b1;
            end
        end
    end

    // in_ready depends only on select/broadcast and slot state, never on in_valid.
    assign in_ready = in_bcast ? (&can_load) : (!in_range || (|(sel_hit & can_load)));
    assign accept   = in_valid && in_ready;
    assign load     = {NUM_OUT{accept}} & sel_hit;
    assign drop     = accept && !in_bcast && !in_range;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        stream_demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .load   (load[k]),
            .data_in(in_data),
            .ready  (out_ready[k]),
            .valid  (out_valid[k]),
            .data   (out_data[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
        end
    end

`ifdef STREAM_DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (out_valid[k] && out_ready[k] && (stat_cnt[k*STAT_W +: STAT_W] != STAT_MAX)) begin
                    stat_cnt[k*STAT_W +: STAT_W] <= stat_cnt[k*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
            if (drop && (drop_cnt != STAT_MAX)) begin
                drop_cnt <= drop_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb/tb_stream_demux_1ton.sv - self-checking bench for stream_demux_1ton (4-channel and 3-channel instances)
module tb_stream_demux_1ton;

    typedef struct packed {
        logic [3:0]        valid;
        logic [3:0][7:0]   data;
        logic              drop;
        logic [3:0][15:0]  stat;
        logic [15:0]       dcnt;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast, in_valid, in_ready, drop_pulse;
    logic [31:0] out_data;
    logic [3:0]  out_valid, out_ready;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic        in_bcast3, in_valid3, in_ready3, drop_pulse3;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3, out_ready3;
`ifdef STREAM_DEMUX_STATS_EN
    logic [63:0] stat_cnt;
    logic [15:0] drop_cnt;
    logic [47:0] stat_cnt3;
    logic [15:0] drop_cnt3;
`endif

    int      vectors = 0;
    int      miscompares = 0;
    bit      armed = 1'b0;
    mstate_t m4 = '0;
    mstate_t m3 = '0;

    always #5 clk = ~clk;

    stream_demux_1ton #(.WIDTH(8), .NUM_OUT(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .drop_pulse(drop_pulse)
`ifdef STREAM_DEMUX_STATS_EN
        , .stat_cnt(stat_cnt), .drop_cnt(drop_cnt)
`endif
    );

    stream_demux_1ton #(.WIDTH(8), .NUM_OUT(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .drop_pulse(drop_pulse3)
`ifdef STREAM_DEMUX_STATS_EN
        , .stat_cnt(stat_cnt3), .drop_cnt(drop_cnt3)
`endif
    );

    function automatic logic m_ready(mstate_t s, int n, logic [3:0] ordy, logic bc, int sel);
        logic ok;
        ok = 1'b1;
        if (bc) begin
            for (int k = 0; k < n; k++) if (s.valid[k] && !ordy[k]) ok = 1'b0;
        end else if (sel < n) begin
            ok = !s.valid[sel] || ordy[sel];
        end
        return ok;
    endfunction

    function automatic mstate_t m_next(mstate_t s, int n, logic [3:0] ordy, logic bc, int sel,
                                       logic vin, logic [7:0] din, logic rs);
        mstate_t r;
        logic    acc;
        if (rs) return '0;
        acc    = vin && m_ready(s, n, ordy, bc, sel);
        r      = s;
        r.drop = acc && !bc && (sel >= n);
        if (r.drop && s.dcnt != 16'hFFFF) r.dcnt = s.dcnt + 16'd1;
        for (int k = 0; k < n; k++) begin
            if (s.valid[k] && ordy[k] && s.stat[k] != 16'hFFFF) r.stat[k] = s.stat[k] + 16'd1;
            if (acc && (bc || sel == k)) begin
                r.valid[k] = 1'b1;
                r.data[k]  = din;
            end else if (s.valid[k] && ordy[k]) begin
                r.valid[k] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m4 <= m_next(m4, 4, out_ready, in_bcast, int'(in_sel), in_valid, in_data, rst);
        m3 <= m_next(m3, 3, {1'b0, out_ready3}, in_bcast3, int'(in_sel3), in_valid3, in_data3, rst);
        if (rst) armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready",    64'(in_ready),    64'(m_ready(m4, 4, out_ready, in_bcast, int'(in_sel))));
            check("out_valid",   64'(out_valid),   64'(m4.valid));
            check("out_data",    64'(out_data),    64'(m4.data));
            check("drop_pulse",  64'(drop_pulse),  64'(m4.drop));
            check("in_ready3",   64'(in_ready3),   64'(m_ready(m3, 3, {1'b0, out_ready3}, in_bcast3, int'(in_sel3))));
            check("out_valid3",  64'(out_valid3),  64'(m3.valid[2:0]));
            check("out_data3",   64'(out_data3),   64'(m3.data[2:0]));
            check("drop_pulse3", 64'(drop_pulse3), 64'(m3.drop));
`ifdef STREAM_DEMUX_STATS_EN
            check("stat_cnt",    stat_cnt,         64'(m4.stat));
            check("drop_cnt",    64'(drop_cnt),    64'(m4.dcnt));
            check("stat_cnt3",   64'(stat_cnt3),   64'(m3.stat[2:0]));
            check("drop_cnt3",   64'(drop_cnt3),   64'(m3.dcnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_data = 8'hA5; in_sel = 2'd2; in_bcast = 1'b0; in_valid = 1'b1; out_ready = 4'hF;
        in_data3 = 8'h00; in_sel3 = 2'd0; in_bcast3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 3'b000;

        // reset with a word presented, then unicast to channel 2
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data",  64'(out_data),  64'h0);
        rst = 1'b0;
        tick();
        check("uni_valid", 64'(out_valid), 64'h4);
        check("uni_lane2", 64'(out_data[23:16]), 64'hA5);
        in_valid = 1'b0;
        tick();

        // backpressure on channel 1
        out_ready = 4'b1101; in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_data = 8'h22; #1;
        check("bp_ready_lo", 64'(in_ready), 64'h0);
        tick();
        check("bp_hold",     64'(out_data[15:8]), 64'h11);
        out_ready = 4'b1111; #1;
        check("bp_ready_hi", 64'(in_ready), 64'h1);
        tick();
        check("bp_pass",     64'(out_data[15:8]), 64'h22);
        in_valid = 1'b0;
        tick();

        // broadcast blocked by a full channel 2
        out_ready = 4'b1011; in_sel = 2'd2; in_data = 8'h77; in_valid = 1'b1;
        tick();
        in_bcast = 1'b1; in_data = 8'h3C; #1;
        check("bc_ready_lo", 64'(in_ready), 64'h0);
        tick();
        check("bc_hold2",    64'(out_data[23:16]), 64'h77);
        out_ready = 4'b1111; #1;
        check("bc_ready_hi", 64'(in_ready), 64'h1);
        tick();
        check("bc_valid",    64'(out_valid), 64'hF);
        check("bc_data",     64'(out_data), 64'h3C3C3C3C);
        in_valid = 1'b0; in_bcast = 1'b0;
        tick();

        // back-to-back streaming to channel 0
        in_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i); in_valid = 1'b1; #1;
            check("st_ready", 64'(in_ready), 64'h1);
            tick();
            check("st_lane0", 64'({out_valid[0], out_data[7:0]}), 64'({1'b1, 8'(i)}));
        end
        in_valid = 1'b0;
        tick();

        // out-of-range select on the 3-channel instance
        in_sel3 = 2'd3; in_data3 = 8'hFF; in_valid3 = 1'b1; #1;
        check("drop_ready", 64'(in_ready3), 64'h1);
        tick();
        check("drop_pulse_hi", 64'(drop_pulse3), 64'h1);
        check("drop_no_valid", 64'(out_valid3), 64'h0);
        in_valid3 = 1'b0;
        tick();
        check("drop_pulse_lo", 64'(drop_pulse3), 64'h0);

        // randomized traffic, including mid-stall select changes and occasional reset
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_sel     = 2'($urandom_range(0, 3));
            in_bcast   = ($urandom_range(0, 7) == 0);
            in_data    = 8'($urandom);
            out_ready  = 4'($urandom) | 4'($urandom);
            in_valid3  = ($urandom_range(0, 9) < 7);
            in_sel3    = 2'($urandom_range(0, 3));
            in_bcast3  = ($urandom_range(0, 7) == 0);
            in_data3   = 8'($urandom);
            out_ready3 = 3'($urandom) | 3'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0; in_bcast = 1'b0; in_bcast3 = 1'b0;

`ifdef STREAM_DEMUX_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 4'hF; in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        check("stat_lane3", 64'(stat_cnt[63:48]), 64'd5);
        in_sel3 = 2'd3; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        check("drop_cnt_one", 64'(drop_cnt3), 64'd1);
        in_sel = 2'd0; in_valid = 1'b1;
        repeat (70000) tick();
        in_valid = 1'b0;
        tick();
        check("stat_sat", 64'(stat_cnt[15:0]), 64'hFFFF);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1ton

Overview:
- Parametrised 1-to-N stream demultiplexer with a valid/ready handshake and a registered one-entry holding slot per output channel.
- Replaces the 1-to-4 combinational demux wherever the downstream consumers can apply backpressure.
- Adds a broadcast mode, a drop path for out-of-range selects, and full throughput per channel.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- WIDTH, 8, data width in bits.
- NUM_OUT, 4, number of output channels, minimum 2.
- SEL_W, $clog2(NUM_OUT), select width; localparam derived from NUM_OUT, not overridable.

Ports:
- clk  in  1  single clock; all logic samples on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  WIDTH  input payload.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  1 = write payload to all channels; in_sel ignored.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- out_data  out  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  NUM_OUT  channel k slot full.
- out_ready  in  NUM_OUT  consumer k takes the word.
- drop_pulse  out  1  one-cycle flag: the previous accepted word had an out-of-range select.

Behaviour:
- Reset, synchronous on rst=1: out_valid=0, out_data=0, drop_pulse=0. Reset overrides any accept or drain in the same cycle; a word presented during reset is lost.
- Per-channel slot states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain (out_valid[k] & out_ready[k]) with no load that cycle.
  - FULL with simultaneous drain and load stays FULL and takes the new data (pass-through).
- can_load[k] = !out_valid[k] | out_ready[k]. Pure combinational; no combinational path from in_valid to in_ready.
- in_ready:
  - in_bcast=1: AND of can_load over all channels.
  - in_bcast=0 with in_sel < NUM_OUT: can_load[in_sel].
  - in_bcast=0 with in_sel >= NUM_OUT: 1, because the word is accepted and dropped.
- Accept = in_valid & in_ready.
  - Unicast: load slot in_sel only.
  - Broadcast: load every slot in the same cycle.
  - Out-of-range select: no slot is loaded, and drop_pulse=1 in the next cycle only.
- Latency: data accepted in cycle t appears on out_data/out_valid in cycle t+1.
- Throughput: one word per cycle sustained into a channel whose out_ready is held high.
- Unselected channels hold their data and valid. Outputs never drive z or x.
- out_data[k] changes only on a load of channel k. It is stable while out_valid[k]=1 and out_ready[k]=0.
- in_sel and in_bcast are sampled only on accept. Changing either while in_valid=1 and in_ready=0 is legal; the value present at accept wins.
- When NUM_OUT is a power of two, the drop path is unreachable and drop_pulse stays 0.

Optional Feature:
- Macro: STREAM_DEMUX_STATS_EN.
- Defined:
  - Adds output stat_cnt, NUM_OUT*16 bits: per-channel 16-bit transfer counters, incremented on each drain and saturating at 16'hFFFF.
  - Adds output drop_cnt, 16 bits: counts drops and saturates.
  - rst clears all counters.
  - A broadcast counts one per channel as each channel drains.
- Undefined: the stat_cnt and drop_cnt ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package stream_demux_pkg holds:
  - STAT_W = 16 and the saturation max constant.
  - The slot-state enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module stream_demux_slot: a one-entry register with load, data_in, ready, valid and data; instantiated NUM_OUT times in a generate loop.
- Top level holds the select decode, the ready logic, and the drop and stats logic.

Test Plan:
1. Reset then unicast. Hold rst=1 for 2 cycles with in_valid=1, then send in_sel=2, in_data=8'hA5 with all out_ready=1 -> during reset nothing is loaded and outputs stay 0; out_valid=4'b0100 and out_data[23:16]=8'hA5 one cycle after accept; other channels unchanged.
2. Backpressure. Set out_ready[1]=0 and send 8'h11 then 8'h22 to channel 1 -> the second word stalls with in_ready=0 and out_data[15:8] stays 8'h11. Raise out_ready[1] -> 8'h22 loads in that cycle with no bubble.
3. Broadcast. Set in_bcast=1, in_data=8'h3C with out_ready=4'b1011 and channel 2 full -> in_ready=0. Drain channel 2 -> accept; all four out_valid=1 and all lanes hold 8'h3C.
4. Streaming. Send 8 back-to-back words to channel 0 with out_ready[0]=1 -> in_ready stays 1 and consumer 0 receives 0..7 in order, one per cycle.
5. Drop path. Use NUM_OUT=3, in_sel=3, in_data=8'hFF -> accepted; drop_pulse=1 for exactly one cycle; no out_valid change.
6. Stats, with STREAM_DEMUX_STATS_EN defined. Send 5 words to channel 3, then 1 drop -> stat_cnt lane 3 = 5 and drop_cnt = 1. Force 70000 transfers -> the counter saturates at 16'hFFFF.
